abm_drain_ctl: RTL and testbench
================================

# abm_drain_ctl

Sequencer for the muxed simple-dual-port RAM. It owns `select_s1`, which chooses the AXI writer (S0 or S1) that fills the RAM. It detects the end of each fill through `last_word_written`, then drains the full RAM through the read port (`addrb`/`dob`) onto an AXI4-Stream master with full backpressure support. When the drain completes it hands the write port to the next source for the following frame.

## Interface
- `DW`, 512: RAM and stream data width.
- `DD`, 16384: RAM depth in words; one frame = `DD` words.
- `RD_LAT`, 2: read latency of the RAM in cycles, from `addrb` to `dob` valid (1..4).
- `clk` input 1: the single clock.
- `resetn` input 1: asynchronous active-low reset.
- `alternate` input 1: 1 = toggle the source after every frame; 0 = use `sel_req`.
- `sel_req` input 1: requested source when `alternate`=0; sampled only in SWITCH.
- `select_s1` output 1: drives the RAM mux; 1 = S1 writes.
- `last_word_written` input 1: single-cycle pulse from the RAM.
- `addrb` output $clog2(DD): RAM read address.
- `dob` input DW: RAM read data.
- `M_AXIS_TDATA` output DW: stream data.
- `M_AXIS_TVALID` output 1: stream valid.
- `M_AXIS_TLAST` output 1: high on word `DD`-1.
- `M_AXIS_TREADY` input 1: stream ready.
- `busy` output 1: high in DRAIN and SWITCH.
- `frame_count` output 32: count of completed drains; wraps.
- `overrun` output 1: sticky; set by `last_word_written` outside FILL.

## Operation
- States:
  - FILL: wait for `last_word_written`, then go to DRAIN.
  - DRAIN: issue reads and stream them out. Once all `DD` words are accepted downstream, go to SWITCH.
  - SWITCH: one cycle. Set `select_s1` to `alternate ? ~select_s1 : sel_req`, increment `frame_count`, go to FILL.
- Read issue:
  - Read address counter `rd_addr` runs 0..`DD`-1; `addrb`=`rd_addr`.
  - A read is issued in a DRAIN cycle only when `issued < DD` and `fifo_count + inflight < FIFO_DEPTH`, where `FIFO_DEPTH` = `RD_LAT`+2.
  - `inflight` counts issued reads whose data has not yet landed.
- Data path:
  - A valid-bit shift register of length `RD_LAT` tags returning `dob` words.
  - Tagged words are pushed into the output FIFO. The credit check guarantees the FIFO never overflows; a push to a full FIFO is a design error (bench assertion).
  - `M_AXIS_TVALID` = FIFO not empty. Pop on `TVALID && TREADY`.
- TLAST: an output word counter 0..`DD`-1 advances on each handshake; `TLAST` = (count == `DD`-1) && `TVALID`.
- DRAIN exits on the handshake of the TLAST word. At that point `issued`=`DD`, `inflight`=0 and the FIFO is empty.
- `last_word_written` in DRAIN or SWITCH: set `overrun`, no state change, no data dropped by this block.
- Arithmetic:
  - Address and output word counters are $clog2(DD) bits wide.
  - `issued` is $clog2(DD)+1 bits wide so that it can hold `DD`.
  - `frame_count` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - State = FILL.
  - `select_s1`=0, `addrb`=0, `M_AXIS_TVALID`=0, `M_AXIS_TLAST`=0, `busy`=0, `frame_count`=0, `overrun`=0.
  - FIFO and counters cleared.
- Reset mid-DRAIN aborts the frame immediately. No partial TLAST is emitted.
- Latency, with the `last_word_written` pulse at cycle T:
  - DRAIN and first `addrb`=0 at T+1.
  - First `TVALID` at T+2+`RD_LAT`.
- Throughput with `TREADY` held at 1: one word per cycle, with TLAST at T+1+`RD_LAT`+`DD`.
  - SWITCH follows the cycle after that, and FILL (with the new `select_s1`) the cycle after SWITCH.
- Backpressure:
  - `TDATA` and `TLAST` are held stable while `TVALID && !TREADY`.
  - Reads stall within `FIFO_DEPTH` words.
- `select_s1` changes only in SWITCH, never during DRAIN or FILL.

## Structure
- Shared package `abm_pkg`:
  - State encoding (FILL=0, DRAIN=1, SWITCH=2).
  - `FIFO_DEPTH` = `RD_LAT`+2 derivation.
- Sub-module `abm_drain_fifo`:
  - Small synchronous show-ahead FIFO with `DW`, `DEPTH` parameters and count output.
  - Register-based, not block RAM.
- All other logic lives in `abm_drain_ctl`.

## Test plan
All scenarios use `DD`=16, `RD_LAT`=2, and a RAM model loaded with word i = i.
- Pulse at T=10 with `TREADY`=1 → first `TVALID` at 14; data 0..15 on consecutive cycles; `TLAST` only on 15 at cycle 29; `frame_count`=1; `busy` falls at 31.
- `alternate`=1, three frames → `select_s1` goes 0→1→0→1, changing only in SWITCH.
- `alternate`=0, `sel_req`=1 asserted mid-DRAIN → `select_s1` stays 0 until SWITCH, then becomes 1.
- Random `TREADY` (50%) → stream data exactly 0..15 in order; `TDATA` stable under stall; FIFO never overflows (assertion).
- `last_word_written` during DRAIN → `overrun`=1 and stays 1; the current frame completes with 16 words.
- `resetn` low at output word 7 → all outputs reach reset values asynchronously; the next pulse after reset yields a clean frame 0..15.

Source files
------------

// File: rtl/abm_pkg.sv
// Shared definitions for the ABM drain sequencer: FSM encoding and FIFO sizing.
package abm_pkg;

    typedef enum logic [1:0] {
        StFill   = 2'd0,
        StDrain  = 2'd1,
        StSwitch = 2'd2
    } abm_state_e;

    // Enough slots to absorb every read still in the RAM pipeline plus slack for a full-rate stream.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/abm_drain_fifo.sv
// Small register-based show-ahead FIFO: the head word is visible on rdata_o while not empty.
module abm_drain_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push_i,
    input  logic [DW-1:0]                wdata_i,
    input  logic                         pop_i,
    output logic [DW-1:0]                rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer, occupancy and storage next-state; a push into a full FIFO is dropped.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
        end
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/abm_drain_ctl.sv
// Frame sequencer: waits for a RAM fill, drains it onto AXI4-Stream, then hands the
// write port to the next source.
module abm_drain_ctl
    import abm_pkg::*;
#(
    parameter int DW     = 512,
    parameter int DD     = 16384,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   alternate,
    input  logic                   sel_req,
    output logic                   select_s1,
    input  logic                   last_word_written,
    output logic [$clog2(DD)-1:0]  addrb,
    input  logic [DW-1:0]          dob,
    output logic [DW-1:0]          M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic                   busy,
    output logic [31:0]            frame_count,
    output logic                   overrun
);

    localparam int AW         = $clog2(DD);
    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DD - 1);

    abm_state_e          state_q, state_d;
    logic                sel_q, sel_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [AW:0]         issued_q, issued_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [AW-1:0]       out_cnt_q, out_cnt_d;
    logic [31:0]         frame_cnt_q, frame_cnt_d;
    logic                overrun_q, overrun_d;

    logic                issue, land, hs, drain_done;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_cnt;

    // Credit check: never have more words in flight plus buffered than the FIFO holds.
    assign issue = (state_q == StDrain) && (int'(issued_q) < DD)
                   && ((int'(fifo_cnt) + int'(inflight_q)) < FIFO_DEPTH);
    assign land       = vld_q[RD_LAT-1];
    assign hs         = !fifo_empty && M_AXIS_TREADY;
    assign drain_done = hs && (out_cnt_q == LAST_IDX);

    abm_drain_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (land),
        .wdata_i (dob),
        .pop_i   (hs),
        .rdata_o (M_AXIS_TDATA),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:   if (last_word_written) state_d = StDrain;
            StDrain:  if (drain_done) state_d = StSwitch;
            StSwitch: state_d = StFill;
            default:  state_d = StFill;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != StFill);
    end

    // Valid tags ride alongside the RAM read pipeline so returning dob words are known-good.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Drain counters, source selection and status next-state.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        issued_d    = issued_q;
        inflight_d  = inflight_q;
        out_cnt_d   = out_cnt_q;
        sel_d       = sel_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q | (last_word_written && (state_q != StFill));

        if (issue) begin
            rd_addr_d = (rd_addr_q == LAST_IDX) ? '0 : rd_addr_q + AW'(1);
            issued_d  = issued_q + (AW+1)'(1);
        end
        if (issue && !land) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && land) begin
            inflight_d = inflight_q - CW'(1);
        end
        if (hs) begin
            out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + AW'(1);
        end

        // Frame boundary: rearm the read side and hand the write port over.
        if (state_q == StSwitch) begin
            sel_d       = alternate ? ~sel_q : sel_req;
            frame_cnt_d = frame_cnt_q + 32'd1;
            issued_d    = '0;
            rd_addr_d   = '0;
            out_cnt_d   = '0;
        end
    end

    // Datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr_q   <= '0;
            issued_q    <= '0;
            inflight_q  <= '0;
            vld_q       <= '0;
            out_cnt_q   <= '0;
            sel_q       <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            vld_q       <= vld_d;
            out_cnt_q   <= out_cnt_d;
            sel_q       <= sel_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign addrb         = rd_addr_q;
    assign select_s1     = sel_q;
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TLAST  = !fifo_empty && (out_cnt_q == LAST_IDX);
    assign frame_count   = frame_cnt_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_abm_drain_ctl.sv
// Scoreboard bench for abm_drain_ctl with a small RAM model (word i = i).
module tb_abm_drain_ctl;
    import abm_pkg::*;

    localparam int DW         = 64;
    localparam int DD         = 16;
    localparam int RD_LAT     = 2;
    localparam int AW         = $clog2(DD);
    localparam int FIFO_DEPTH = RD_LAT + 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          alternate;
    logic          sel_req;
    logic          select_s1;
    logic          last_word_written;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic          busy;
    logic [31:0]   frame_count;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    int first_valid_cyc;
    int tlast_cyc;
    int words_seen;
    logic          sel_model = 1'b0;
    logic [31:0]   frame_model = 32'd0;
    logic          ovr_model = 1'b0;

    // Monitor history
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_sel = 1'b0;
    abm_state_e    prev_state = StFill;

    // RAM read port model with a two-cycle latency.
    logic [DW-1:0] ram_p0, ram_p1;

    abm_drain_ctl #(
        .DW     (DW),
        .DD     (DD),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .alternate         (alternate),
        .sel_req           (sel_req),
        .select_s1         (select_s1),
        .last_word_written (last_word_written),
        .addrb             (addrb),
        .dob               (dob),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .busy              (busy),
        .frame_count       (frame_count),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_p0 <= DW'(addrb);
        ram_p1 <= ram_p0;
    end
    assign dob = ram_p1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_values();
        check("rst_select_s1", 64'(select_s1), 64'd0);
        check("rst_addrb", 64'(addrb), 64'd0);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold-under-stall,
    // select changes and FIFO overflow.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            prev_sel   = select_s1;
            prev_state = StFill;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", 64'(M_AXIS_TVALID), 64'd1);
                check("stall_tdata", 64'(M_AXIS_TDATA), 64'(prev_data));
                check("stall_tlast", 64'(M_AXIS_TLAST), 64'(prev_last));
            end
            if (M_AXIS_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", M_AXIS_TDATA);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("stream_tdata", 64'(M_AXIS_TDATA), 64'(e.data));
                    check("stream_tlast", 64'(M_AXIS_TLAST), 64'(e.last));
                    words_seen++;
                    if (M_AXIS_TLAST && tlast_cyc < 0) tlast_cyc = cyc;
                end
            end
            if (dut.u_fifo.push_i) begin
                checks++;
                if (int'(dut.u_fifo.count_o) == FIFO_DEPTH && !dut.u_fifo.pop_i) begin
                    errors++;
                    $display("FAIL fifo_overflow actual=push_when_full required=no_push");
                end
            end
            if (select_s1 !== prev_sel) begin
                check("select_change_in_switch", 64'(prev_state), 64'(StSwitch));
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
            prev_sel   = select_s1;
            prev_state = dut.state_q;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < DD; i++) begin
            exp_q.push_back('{data: DW'(i), last: (i == DD - 1)});
        end
        first_valid_cyc = -1;
        tlast_cyc = -1;
        words_seen = 0;
    endtask

    // One complete frame. ovr_k/sreq_k: cycle after the fill pulse at which to inject
    // a stray last_word_written / change sel_req (0 = never).
    task automatic run_frame(input bit rnd, input int ovr_k, input int sreq_k, input bit sreq_v,
                             input bit alt, input bit timing);
        int t0;
        int busy_fall;
        bit done;
        alternate = alt;
        push_frame();
        @(posedge clk);
        #1;
        last_word_written = 1'b1;
        M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        t0 = cyc;
        done = 1'b0;
        busy_fall = -1;
        for (int k = 1; k <= 400 && !done; k++) begin
            @(posedge clk);
            #1;
            last_word_written = (k == ovr_k);
            if (k == ovr_k) ovr_model = 1'b1;
            if (k == sreq_k) sel_req = sreq_v;
            M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sreq_k > 0 && k == sreq_k + 2) begin
                check("select_hold_mid_drain", 64'(select_s1), 64'(sel_model));
            end
            if (ovr_k > 0 && k == ovr_k + 2) begin
                check("overrun_set_in_drain", 64'(overrun), 64'd1);
            end
            @(negedge clk);
            if (!busy && k > 1) begin
                done = 1'b1;
                busy_fall = cyc;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=busy required=idle_within_400");
        end
        sel_model = alt ? ~sel_model : sel_req;
        frame_model = frame_model + 32'd1;
        check("frame_words_left", 64'(exp_q.size()), 64'd0);
        check("frame_word_count", 64'(words_seen), 64'(DD));
        check("frame_count", 64'(frame_count), 64'(frame_model));
        check("select_s1", 64'(select_s1), 64'(sel_model));
        check("overrun", 64'(overrun), 64'(ovr_model));
        if (timing) begin
            check("lat_first_tvalid", 64'(first_valid_cyc - t0), 64'(2 + RD_LAT));
            check("lat_tlast", 64'(tlast_cyc - t0), 64'(1 + RD_LAT + DD));
            check("lat_busy_fall", 64'(busy_fall - t0), 64'(3 + RD_LAT + DD));
        end
        exp_q.delete();
    endtask

    // Abort a frame with reset once output word 7 has been accepted.
    task automatic reset_mid_frame();
        bit reached;
        alternate = 1'b1;
        push_frame();
        @(posedge clk);
        #1;
        last_word_written = 1'b1;
        M_AXIS_TREADY = 1'b1;
        reached = 1'b0;
        for (int k = 1; k <= 100 && !reached; k++) begin
            @(posedge clk);
            #1;
            last_word_written = 1'b0;
            @(negedge clk);
            if (words_seen >= 8) reached = 1'b1;
        end
        check("reset_point_reached", 64'(reached), 64'd1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        sel_model = 1'b0;
        frame_model = 32'd0;
        ovr_model = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check_reset_values();
    endtask

    initial begin
        resetn = 1'b0;
        alternate = 1'b1;
        sel_req = 1'b0;
        last_word_written = 1'b0;
        M_AXIS_TREADY = 1'b0;
        first_valid_cyc = -1;
        tlast_cyc = -1;
        words_seen = 0;
        repeat (3) @(negedge clk);
        check_reset_values();
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);  // full rate, latency checks, sel 0->1
        run_frame(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);  // random backpressure, sel 1->0
        run_frame(1'b0, 6, 0, 1'b0, 1'b1, 1'b0);  // stray pulse in DRAIN, sel 0->1
        run_frame(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);  // sel_req=0 -> sel 0, overrun sticky
        run_frame(1'b0, 0, 5, 1'b1, 1'b0, 1'b0);  // sel_req=1 mid-DRAIN -> sel 1 at SWITCH
        reset_mid_frame();
        sel_req = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);  // clean frame after reset

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
